// File: rtl/aes_result_checker_pkg.sv
// ============================================================================
// Module : aes_result_checker_pkg
// Brief  : Shared types and constants for the AES result checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_result_checker_pkg;

    localparam int NUM_VECTORS_DEFAULT = 21;
    localparam int VEC_W               = 128;
    localparam int IDX_W               = 5;
    localparam int ERR_W               = 6;

    typedef logic [VEC_W-1:0] aes_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/aes_result_checker_if.sv
// ============================================================================
// Module : aes_result_checker_if
// Brief  : Valid/ready result channel from the AES core to the checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_result_checker_if;
    import aes_result_checker_pkg::*;

    logic     ct_valid;
    aes_vec_t ct_data;
    logic     ct_ready;

    modport master (output ct_valid, output ct_data, input ct_ready);
    modport slave  (input ct_valid, input ct_data, output ct_ready);

endinterface

`default_nettype wire

// File: rtl/aes_expected_rom.sv
// ============================================================================
// Module : aes_expected_rom
// Brief  : Expected ciphertexts, KeySbox set (zero plaintext, AES-128).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_expected_rom
    import aes_result_checker_pkg::*;
#(
    parameter int NUM_VECTORS = NUM_VECTORS_DEFAULT
) (
    input  logic [IDX_W-1:0] idx,
    output aes_vec_t         expected
);

    aes_vec_t entry;

    always_comb begin
        entry = '0;
        case (idx)
            5'd0:    entry = 128'h6d251e6944b051e04eaa6fb4dbf78465;
            5'd1:    entry = 128'h6e29201190152df4ee058139def610bb;
            5'd2:    entry = 128'hc3b44b95d9d2f25670eee9a0de099fa3;
            5'd3:    entry = 128'h5d9b05578fc944b3cf1ccf0e746cd581;
            5'd4:    entry = 128'hf7efc89d5dba578104016ce5ad659c05;
            5'd5:    entry = 128'h0306194f666d183624aa230a8b264ae7;
            5'd6:    entry = 128'h858075d536d79ccee571f7d7204b1f67;
            5'd7:    entry = 128'h35870c6a57e9e92314bcb8087cde72ce;
            5'd8:    entry = 128'h6c68e9be5ec41e22c825b7c7affb4363;
            5'd9:    entry = 128'hf5df39990fc688f1b07224cc03e86cea;
            5'd10:   entry = 128'hbba071bcb470f8f6586e5d3add18bc66;
            5'd11:   entry = 128'h43c9f7e62f5d288bb27aa40ef8fe1ea8;
            5'd12:   entry = 128'h3580d19cff44f1014a7c966a69059de5;
            5'd13:   entry = 128'h806da864dd29d48deafbe764f8202aef;
            5'd14:   entry = 128'ha303d940ded8f0baff6f75414cac5243;
            5'd15:   entry = 128'hc2dabd117f8a3ecabfbb11d12194d9d0;
            5'd16:   entry = 128'hfff60a4740086b3b9c56195b98d91a7b;
            5'd17:   entry = 128'h8146a08e2357f0caa30ca8c94d1a0544;
            5'd18:   entry = 128'h4b98e06d356deb07ebb824e5713f7be3;
            5'd19:   entry = 128'h7a20a53d460fc9ce0423a7a0764c6cf2;
            5'd20:   entry = 128'hf4a70d8af877f9b02b4c40df57d45b17;
            default: entry = '0;
        endcase
    end

    // Indices past the configured run length read as zero.
    assign expected = (int'(idx) < NUM_VECTORS) ? entry : '0;

endmodule

`default_nettype wire

// File: rtl/aes_result_checker.sv
// ============================================================================
// Module : aes_result_checker
// Brief  : Compares AES core results against a KAT ROM with a watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_result_checker
    import aes_result_checker_pkg::*;
#(
    parameter int CYPHER_SIZE    = 128,
    parameter int NUM_VECTORS    = NUM_VECTORS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    aes_result_checker_if.slave  ct_if,
    output logic [IDX_W-1:0]     vec_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic                 timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // Key width only travels alongside the stimulus generator.
    if (CYPHER_SIZE <= 0) begin : g_cypher_size_unused
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [IDX_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             timeout_q, timeout_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ct_ready_q, ct_ready_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    aes_vec_t expected;
    logic     accept;
    logic     mismatch;
    logic     last_vec;

    aes_expected_rom #(.NUM_VECTORS(NUM_VECTORS)) u_rom (
        .idx      (vec_idx_q),
        .expected (expected)
    );

    assign accept   = ct_if.ct_valid & ct_ready_q;
    assign mismatch = (ct_if.ct_data != expected);
    assign last_vec = (int'(vec_idx_q) == NUM_VECTORS - 1);

    always_comb begin
        state_d          = state_q;
        vec_idx_d        = vec_idx_q;
        err_count_d      = err_count_q;
        first_fail_idx_d = first_fail_idx_q;
        timeout_d        = timeout_q;
        pass_d           = pass_q;
        done_d           = done_q;
        busy_d           = busy_q;
        ct_ready_d       = ct_ready_q;
        wd_d             = wd_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d          = ST_RUN;
                    vec_idx_d        = '0;
                    err_count_d      = '0;
                    first_fail_idx_d = '0;
                    timeout_d        = 1'b0;
                    pass_d           = 1'b0;
                    done_d           = 1'b0;
                    wd_d             = '0;
                    busy_d           = 1'b1;
                    ct_ready_d       = 1'b1;
                end
            end
            ST_RUN: begin
                // An accept always wins over a watchdog expiry in the same cycle.
                if (accept) begin
                    wd_d      = '0;
                    vec_idx_d = vec_idx_q + 1'b1;
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            first_fail_idx_d = vec_idx_q;
                        end
                    end
                    if (last_vec) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        pass_d     = (err_count_d == '0);
                        busy_d     = 1'b0;
                        ct_ready_d = 1'b0;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    busy_d     = 1'b0;
                    ct_ready_d = 1'b0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                ct_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            vec_idx_q        <= '0;
            err_count_q      <= '0;
            first_fail_idx_q <= '0;
            timeout_q        <= 1'b0;
            pass_q           <= 1'b0;
            done_q           <= 1'b0;
            busy_q           <= 1'b0;
            ct_ready_q       <= 1'b0;
            wd_q             <= '0;
        end else begin
            state_q          <= state_d;
            vec_idx_q        <= vec_idx_d;
            err_count_q      <= err_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            timeout_q        <= timeout_d;
            pass_q           <= pass_d;
            done_q           <= done_d;
            busy_q           <= busy_d;
            ct_ready_q       <= ct_ready_d;
            wd_q             <= wd_d;
        end
    end

    assign ct_if.ct_ready = ct_ready_q;
    assign vec_idx        = vec_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign timeout        = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_result_checker.sv
// ============================================================================
// Module : tb_aes_result_checker
// Brief  : Directed, table-driven bench for aes_result_checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_result_checker;

    typedef struct {
        logic [127:0] ct;
        logic         flip;
        logic [5:0]   exp_err;
        logic [4:0]   exp_ffi;
    } vec_rec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   vec_idx;
    logic         busy;
    logic         done;
    logic         pass;
    logic [5:0]   err_count;
    logic [4:0]   first_fail_idx;
    logic         timeout;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] kat [21];
    vec_rec_t     tbl [21];

    aes_result_checker_if ct_if ();

    aes_result_checker #(
        .CYPHER_SIZE    (128),
        .NUM_VECTORS    (21),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .ct_if          (ct_if),
        .vec_idx        (vec_idx),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        ct_if.ct_valid = 1'b1;
        ct_if.ct_data  = d;
        tick();
        ct_if.ct_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        ct_if.ct_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"},     busy,             1);
        check({tag, "_ready"},    ct_if.ct_ready,   1);
        check({tag, "_done_clr"}, done,             0);
        check({tag, "_idx_clr"},  vec_idx,          0);
        check({tag, "_err_clr"},  err_count,        0);
        check({tag, "_to_clr"},   timeout,          0);
    endtask

    task automatic build_table(input bit corrupt);
        for (int i = 0; i < 21; i++) begin
            tbl[i].ct      = kat[i];
            tbl[i].flip    = corrupt && (i == 3 || i == 7);
            tbl[i].exp_err = !corrupt ? 6'd0 : (i >= 7) ? 6'd2 : (i >= 3) ? 6'd1 : 6'd0;
            tbl[i].exp_ffi = (corrupt && i >= 3) ? 5'd3 : 5'd0;
        end
    endtask

    task automatic run_table(input string tag, input bit poke_start);
        for (int i = 0; i < 21; i++) begin
            if (poke_start && i == 4) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check($sformatf("%s_ign_start_idx", tag),  vec_idx, 4);
                check($sformatf("%s_ign_start_busy", tag), busy,    1);
                check($sformatf("%s_ign_start_rdy", tag),  ct_if.ct_ready, 1);
            end
            send(tbl[i].ct ^ 128'(tbl[i].flip));
            check($sformatf("%s_idx[%0d]", tag, i), vec_idx,        i + 1);
            check($sformatf("%s_err[%0d]", tag, i), err_count,      tbl[i].exp_err);
            check($sformatf("%s_ffi[%0d]", tag, i), first_fail_idx, tbl[i].exp_ffi);
        end
    endtask

    task automatic check_final(input string tag, input logic exp_pass, input logic [5:0] exp_err,
                               input logic [4:0] exp_ffi, input logic exp_to, input logic [4:0] exp_idx);
        check({tag, "_done"},  done,           1);
        check({tag, "_pass"},  pass,           exp_pass);
        check({tag, "_err"},   err_count,      exp_err);
        check({tag, "_ffi"},   first_fail_idx, exp_ffi);
        check({tag, "_to"},    timeout,        exp_to);
        check({tag, "_idx"},   vec_idx,        exp_idx);
        check({tag, "_busy"},  busy,           0);
        check({tag, "_ready"}, ct_if.ct_ready, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_idx"},   vec_idx,        0);
        check({tag, "_busy"},  busy,           0);
        check({tag, "_done"},  done,           0);
        check({tag, "_pass"},  pass,           0);
        check({tag, "_err"},   err_count,      0);
        check({tag, "_ffi"},   first_fail_idx, 0);
        check({tag, "_to"},    timeout,        0);
        check({tag, "_ready"}, ct_if.ct_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired, want finish");
        $fatal(1, "time limit");
    end

    initial begin
        kat[0]  = 128'h6d251e6944b051e04eaa6fb4dbf78465;
        kat[1]  = 128'h6e29201190152df4ee058139def610bb;
        kat[2]  = 128'hc3b44b95d9d2f25670eee9a0de099fa3;
        kat[3]  = 128'h5d9b05578fc944b3cf1ccf0e746cd581;
        kat[4]  = 128'hf7efc89d5dba578104016ce5ad659c05;
        kat[5]  = 128'h0306194f666d183624aa230a8b264ae7;
        kat[6]  = 128'h858075d536d79ccee571f7d7204b1f67;
        kat[7]  = 128'h35870c6a57e9e92314bcb8087cde72ce;
        kat[8]  = 128'h6c68e9be5ec41e22c825b7c7affb4363;
        kat[9]  = 128'hf5df39990fc688f1b07224cc03e86cea;
        kat[10] = 128'hbba071bcb470f8f6586e5d3add18bc66;
        kat[11] = 128'h43c9f7e62f5d288bb27aa40ef8fe1ea8;
        kat[12] = 128'h3580d19cff44f1014a7c966a69059de5;
        kat[13] = 128'h806da864dd29d48deafbe764f8202aef;
        kat[14] = 128'ha303d940ded8f0baff6f75414cac5243;
        kat[15] = 128'hc2dabd117f8a3ecabfbb11d12194d9d0;
        kat[16] = 128'hfff60a4740086b3b9c56195b98d91a7b;
        kat[17] = 128'h8146a08e2357f0caa30ca8c94d1a0544;
        kat[18] = 128'h4b98e06d356deb07ebb824e5713f7be3;
        kat[19] = 128'h7a20a53d460fc9ce0423a7a0764c6cf2;
        kat[20] = 128'hf4a70d8af877f9b02b4c40df57d45b17;

        ct_if.ct_valid = 1'b0;
        ct_if.ct_data  = '0;

        // Power-on reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        reset_n = 1'b1;

        // Results offered while idle are not accepted.
        ct_if.ct_valid = 1'b1;
        ct_if.ct_data  = 128'h0;
        repeat (3) tick();
        ct_if.ct_valid = 1'b0;
        check_all_zero("idle_valid");

        // Clean run with an ignored start at vec_idx 4.
        build_table(1'b0);
        do_start("clean_start");
        run_table("clean", 1'b1);
        check_final("clean", 1'b1, 6'd0, 5'd0, 1'b0, 5'd21);

        // Status holds in DONE while results keep arriving.
        ct_if.ct_valid = 1'b1;
        ct_if.ct_data  = kat[0];
        repeat (5) tick();
        ct_if.ct_valid = 1'b0;
        check_final("done_hold", 1'b1, 6'd0, 5'd0, 1'b0, 5'd21);

        // Restart from DONE, results 3 and 7 corrupted.
        build_table(1'b1);
        do_start("mm_start");
        run_table("mm", 1'b0);
        check_final("mm", 1'b0, 6'd2, 5'd3, 1'b0, 5'd21);

        // Watchdog: five results then silence; expiry on the 16th idle edge.
        do_start("to_start");
        for (int i = 0; i < 5; i++) send(kat[i]);
        repeat (15) tick();
        check("to_not_early", done, 0);
        tick();
        check_final("to", 1'b0, 6'd0, 5'd0, 1'b1, 5'd5);

        // Race: final accept lands on the watchdog's last cycle.
        do_start("race_start");
        for (int i = 0; i < 20; i++) send(kat[i]);
        repeat (15) tick();
        check("race_not_early", done, 0);
        send(kat[20]);
        check_final("race", 1'b1, 6'd0, 5'd0, 1'b0, 5'd21);

        // Reset in the middle of a run, away from any clock edge.
        do_start("rst_start");
        for (int i = 0; i < 10; i++) send(kat[i]);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        reset_n = 1'b1;
        ct_if.ct_valid = 1'b1;
        ct_if.ct_data  = kat[0];
        repeat (3) tick();
        ct_if.ct_valid = 1'b0;
        check_all_zero("post_rst_idle");
        build_table(1'b0);
        do_start("post_rst_start");
        run_table("post_rst", 1'b0);
        check_final("post_rst", 1'b1, 6'd0, 5'd0, 1'b0, 5'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_result_checker.md
AES_RESULT_CHECKER -- requirements
Module: aes_result_checker

Interface
REQ-001 SHALL have parameter CYPHER_SIZE, default 128, which is the key width carried for compatibility with the stimulus generator; it is unused in the datapath.
REQ-002 SHALL have parameter NUM_VECTORS, default 21, which is the number of vectors per run; the legal range is 1..32.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, which is the maximum number of cycles between accepted results.
REQ-004 SHALL have one clock and an asynchronous active-low reset, exactly as listed in REQ-005 and REQ-006.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-008 SHALL have port ct_valid, input, 1 bit: the AES core result is valid.
REQ-009 SHALL have port ct_data, input, 128 bits: the AES ciphertext.
REQ-010 SHALL have port ct_ready, output, 1 bit: the checker accepts a result.
REQ-011 SHALL have port vec_idx, output, 5 bits: the index of the next expected vector.
REQ-012 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-013 SHALL have port done, output, 1 bit: the run has finished; it is sticky until the next start.
REQ-014 SHALL have port pass, output, 1 bit: the run finished with no mismatches and no timeout.
REQ-015 SHALL have port err_count, output, 6 bits: the number of mismatches, saturating at 63.
REQ-016 SHALL have port first_fail_idx, output, 5 bits: the index of the first mismatching vector.
REQ-017 SHALL have port timeout, output, 1 bit: the watchdog expired during the run.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE, with all outputs registered.
REQ-019 SHALL leave IDLE for RUN on start; entering RUN clears vec_idx, err_count, first_fail_idx, timeout, pass, done and the watchdog.
REQ-020 SHALL drive ct_ready=1 and busy=1 only in RUN; ct_valid in IDLE or DONE is ignored.
REQ-021 SHALL accept a result when ct_valid and ct_ready are both 1, and compare ct_data with expected[vec_idx] in the same cycle.
REQ-022 SHALL, on a mismatch, increment err_count with saturation at 63, and load first_fail_idx only when err_count was 0.
REQ-023 SHALL increment vec_idx by 1 on each accepted result.
REQ-024 SHALL, on an accepted result at vec_idx==NUM_VECTORS-1, move to DONE on the next edge, with done=1 and pass=(final err_count==0) one cycle after that accept.
REQ-025 SHALL clear the watchdog on each accepted result and increment it otherwise while in RUN.
REQ-026 SHALL, when the watchdog reaches TIMEOUT_CYCLES-1 without an accept, move to DONE with timeout=1 and pass=0.
REQ-027 SHALL give an accepted result priority over a watchdog expiry in the same cycle, so timeout stays 0 for that cycle.
REQ-028 SHALL ignore start while in RUN.
REQ-029 SHALL restart a run on start while in DONE, as in REQ-019.
REQ-030 SHALL hold first_fail_idx at 0 when err_count==0, in which case first_fail_idx is meaningless.
REQ-031 SHALL hold all status outputs stable in DONE until start or reset.

Reset
REQ-032 SHALL, on reset_n=0 and regardless of clk, immediately force the state to IDLE and set vec_idx, err_count, first_fail_idx, timeout, pass, done, busy, ct_ready and the watchdog to 0.
REQ-033 SHALL, on reset in the middle of a run, abandon all partial results.
REQ-034 SHALL, after reset is released, require a new start before accepting results.

Structure
REQ-035 SHALL place the state encoding, the 128-bit vector type and the NUM_VECTORS default in the shared AES package.
REQ-036 SHALL implement the expected-ciphertext table as the sub-module aes_expected_rom: combinational, 5-bit index in, 128 bits out, 0 beyond NUM_VECTORS-1.
REQ-037 SHALL populate aes_expected_rom with the ciphertexts for the KeySbox test set, which uses an all-zero plaintext with the key-generator keys.

Verification
REQ-038 SHALL cover the clean run: start, then 21 results equal to the ROM values -> done=1, pass=1, err_count=0, timeout=0, vec_idx=21.
REQ-039 SHALL cover mismatches: results 3 and 7 corrupted by flipping bit 0 -> err_count=2, first_fail_idx=3, pass=0.
REQ-040 SHALL cover the timeout: start with TIMEOUT_CYCLES=16 and stop after 5 results -> DONE with timeout=1, pass=0, vec_idx=5.
REQ-041 SHALL cover the race: the 21st accept lands in the same cycle as the watchdog expiry -> timeout=0, pass=1.
REQ-042 SHALL cover reset mid-run: reset_n=0 after 10 results -> all outputs 0 in the same cycle; a new start followed by 21 good results -> pass=1.
REQ-043 SHALL cover ignored starts: start pulsed mid-run at vec_idx=4 -> no effect; ct_valid held high in IDLE -> ct_ready=0 and err_count stays 0.
